spu_fetch_buffer: RTL

Instruction-fetch responder on the far side of the SPU program counter. Accepts one fetch request per cycle carrying the even-aligned PC of an instruction pair, issues a read to the instruction local store, captures the 64-bit pair one cycle later, and queues it with its PC in a small FIFO. The FIFO feeds the dual-issue decode stage through a valid/ready handshake. A flush input discards everything in flight on a branch redirect.

---
 rtl/spu_fetch_buffer.sv | 80 ++++++++
 1 files changed

// File: rtl/spu_fetch_buffer.sv
// Instruction-fetch responder: issues local-store reads for pair-aligned PCs and
// queues the returned instruction pairs in a small FIFO feeding dual-issue decode.
module spu_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:9]  pc_in,
  input  logic        pc_valid,
  output logic        fetch_ready,
  input  logic        flush,
  output logic        imem_rd_en,
  output logic [0:9]  imem_addr,
  input  logic [0:63] imem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [0:31] dec_inst0,
  output logic [0:31] dec_inst1,
  output logic [0:9]  dec_pc,
  output logic [0:2]  count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [0:63]   data_mem [DEPTH];
  logic [0:9]    pc_mem   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pend_v;
  logic [0:9]    pend_pc;
  logic [0:2]    count_q;
  logic [3:0]    occupancy;
  logic          push;
  logic          pop;

  // The outstanding read holds a slot so its data always has room when it lands.
  assign occupancy   = {1'b0, count_q} + {3'b000, pend_v};
  assign fetch_ready = occupancy < 4'(DEPTH);
  assign imem_rd_en  = pc_valid && fetch_ready && !flush;
  assign imem_addr   = {pc_in[0:8], 1'b0};

  assign dec_valid = count_q != 3'd0;
  assign push      = pend_v && !flush;
  assign pop       = dec_valid && dec_ready && !flush;
  assign count     = count_q;

  // Gated so storage that was never written is not visible when empty.
  assign dec_inst0 = dec_valid ? data_mem[rd_ptr][0:31]  : 32'd0;
  assign dec_inst1 = dec_valid ? data_mem[rd_ptr][32:63] : 32'd0;
  assign dec_pc    = dec_valid ? pc_mem[rd_ptr]          : 10'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_v  <= 1'b0;
      pend_pc <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      pend_v  <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      pend_v <= imem_rd_en;
      if (imem_rd_en) pend_pc <= imem_addr;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]   <= pend_pc;
    end
  end

endmodule
